// File: rtl/char_pixel_if.sv
`default_nettype none
// ============================================================================
// Module      : char_pixel_if
// Description : Bundles the VGA timing, character attributes, glyph ROM port
//               and pixel outputs of char_pixel_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface char_pixel_if;
    logic [9:0]  h_val;
    logic [9:0]  v_val;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        box_time;
    logic        video_on_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [6:0]  char_code;
    logic [11:0] fg_color;
    logic [10:0] rom_addr;
    logic [15:0] rom_data;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        video_on_out;

    modport slave (
        input  h_val, v_val, x_pos, y_pos, box_time, video_on_in,
               hsync_in, vsync_in, char_code, fg_color, rom_data,
        output rom_addr, rgb, hsync_out, vsync_out, video_on_out
    );

    modport master (
        output h_val, v_val, x_pos, y_pos, box_time, video_on_in,
               hsync_in, vsync_in, char_code, fg_color, rom_data,
        input  rom_addr, rgb, hsync_out, vsync_out, video_on_out
    );
endinterface
`default_nettype wire

// File: rtl/char_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module      : char_pixel_gen
// Description : 3-stage pipeline drawing a 16x16 glyph from a synchronous
//               character ROM. Optional glyph blink with macro CHAR_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module char_pixel_gen #(
    parameter logic [11:0] FG_DEFAULT = 12'hFFF,
    parameter logic [11:0] BG_DEFAULT = 12'h000
) (
    input  logic        clk,
    input  logic        reset_n,
    char_pixel_if.slave bus
);
    localparam logic [11:0] c_BLACK = 12'h000;

    logic [9:0]  w_dx, w_dy;
    logic        w_pix_on, w_blink;

    logic [10:0] rom_addr_q, rom_addr_d;
    logic [3:0]  col1_q, col1_d, col2_q, col2_d;
    logic        box1_q, box1_d, box2_q, box2_d;
    logic        von1_q, von1_d, von2_q, von2_d, von3_q, von3_d;
    logic        hs1_q, hs1_d, hs2_q, hs2_d, hs3_q, hs3_d;
    logic        vs1_q, vs1_d, vs2_q, vs2_d, vs3_q, vs3_d;
    logic [11:0] glyph1_q, glyph1_d, glyph2_q, glyph2_d;
    logic [11:0] rgb_q, rgb_d;

    assign w_dx = bus.h_val - bus.x_pos;
    assign w_dy = bus.v_val - bus.y_pos;
    // Bit 15 is the leftmost pixel, so column c selects bit ~c (15 - c).
    assign w_pix_on = bus.rom_data[~col2_q];

`ifdef CHAR_BLINK_EN
    logic       vsync_prev_q, vsync_prev_d;
    logic [4:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        vsync_prev_d = bus.vsync_in;
        frame_cnt_d  = frame_cnt_q;
        if (vsync_prev_q && !bus.vsync_in) begin
            frame_cnt_d = frame_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vsync_prev_q <= 1'b1;
            frame_cnt_q  <= 5'd0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign w_blink = frame_cnt_q[4];
`else
    assign w_blink = 1'b0;
`endif

    always_comb begin
        rom_addr_d = {bus.char_code, w_dy[3:0]};
        col1_d     = w_dx[3:0];
        box1_d     = bus.box_time;
        von1_d     = bus.video_on_in;
        hs1_d      = bus.hsync_in;
        vs1_d      = bus.vsync_in;
        glyph1_d   = (bus.fg_color == c_BLACK) ? FG_DEFAULT : bus.fg_color;

        col2_d     = col1_q;
        box2_d     = box1_q;
        von2_d     = von1_q;
        hs2_d      = hs1_q;
        vs2_d      = vs1_q;
        glyph2_d   = glyph1_q;

        von3_d     = von2_q;
        hs3_d      = hs2_q;
        vs3_d      = vs2_q;
        rgb_d      = c_BLACK;
        if (von2_q && box2_q) begin
            rgb_d = (w_pix_on && !w_blink) ? glyph2_q : BG_DEFAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rom_addr_q <= 11'd0;
            col1_q     <= 4'd0;
            box1_q     <= 1'b0;
            von1_q     <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            glyph1_q   <= 12'd0;
            col2_q     <= 4'd0;
            box2_q     <= 1'b0;
            von2_q     <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            glyph2_q   <= 12'd0;
            von3_q     <= 1'b0;
            hs3_q      <= 1'b1;
            vs3_q      <= 1'b1;
            rgb_q      <= 12'd0;
        end else begin
            rom_addr_q <= rom_addr_d;
            col1_q     <= col1_d;
            box1_q     <= box1_d;
            von1_q     <= von1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            glyph1_q   <= glyph1_d;
            col2_q     <= col2_d;
            box2_q     <= box2_d;
            von2_q     <= von2_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            glyph2_q   <= glyph2_d;
            von3_q     <= von3_d;
            hs3_q      <= hs3_d;
            vs3_q      <= vs3_d;
            rgb_q      <= rgb_d;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.rgb          = rgb_q;
    assign bus.hsync_out    = hs3_q;
    assign bus.vsync_out    = vs3_q;
    assign bus.video_on_out = von3_q;
endmodule
`default_nettype wire

// File: tb/tb_char_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_pixel_gen
// Description : Directed and randomized self-checking bench for char_pixel_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_pixel_gen;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    char_pixel_if bus ();
    char_pixel_gen u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Character ROM with one-cycle registered read
    logic [15:0] rom [0:2047];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        bit          rst;
        logic [9:0]  h, v, x, y;
        bit          box, von, hs, vs;
        logic [6:0]  code;
        logic [11:0] fg;
        int          frames;
    } pix_t;

    pix_t hist [0:8191];
    int   cyc = 0;
    int   m_frames = 0;
    bit   m_vs_prev = 1'b1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Expected outputs for the pixel whose inputs were applied in cycle p
    task automatic check_pixel(input int p);
        logic [11:0] e_rgb, glyph;
        logic        e_hs, e_vs, e_von, on, blink;
        logic [9:0]  dx, dy;
        logic [15:0] row;
        int          col;
        if (hist[p].rst || hist[p+1].rst || hist[p+2].rst) begin
            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0;
        end else begin
            e_hs  = hist[p].hs;
            e_vs  = hist[p].vs;
            e_von = hist[p].von;
            dx    = hist[p].h - hist[p].x;
            dy    = hist[p].v - hist[p].y;
            row   = rom[{hist[p].code, dy[3:0]}];
            col   = int'(dx[3:0]);
            on    = row[15 - col];
            glyph = (hist[p].fg == 12'h000) ? 12'hFFF : hist[p].fg;
`ifdef CHAR_BLINK_EN
            blink = (hist[p+1].frames >= 16);
`else
            blink = 1'b0;
`endif
            if (!hist[p].von || !hist[p].box) e_rgb = 12'h000;
            else if (on && !blink)            e_rgb = glyph;
            else                              e_rgb = 12'h000;
        end
        chk("model_rgb",      16'(bus.rgb),          16'(e_rgb));
        chk("model_hsync",    16'(bus.hsync_out),    16'(e_hs));
        chk("model_vsync",    16'(bus.vsync_out),    16'(e_vs));
        chk("model_video_on", 16'(bus.video_on_out), 16'(e_von));
    endtask

    // Record the applied inputs, clock one edge, then check the model
    task automatic cycle();
        pix_t e;
        e.rst = !reset_n;
        e.h = bus.h_val; e.v = bus.v_val; e.x = bus.x_pos; e.y = bus.y_pos;
        e.box = bus.box_time; e.von = bus.video_on_in;
        e.hs = bus.hsync_in; e.vs = bus.vsync_in;
        e.code = bus.char_code; e.fg = bus.fg_color;
        if (!reset_n) begin
            m_frames = 0; m_vs_prev = 1'b1;
        end else begin
            if (m_vs_prev && !bus.vsync_in) m_frames = (m_frames + 1) % 32;
            m_vs_prev = bus.vsync_in;
        end
        e.frames = m_frames;
        hist[cyc] = e;
        @(posedge clk);
        @(negedge clk);
        if (cyc >= 2) check_pixel(cyc - 2);
        cyc++;
    endtask

    task automatic set_idle();
        bus.h_val = 10'd0; bus.v_val = 10'd0; bus.x_pos = 10'd0; bus.y_pos = 10'd0;
        bus.box_time = 1'b0; bus.video_on_in = 1'b0;
        bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
        bus.char_code = 7'd0; bus.fg_color = 12'd0;
    endtask

    task automatic set_pix(input logic [9:0] h, input logic [6:0] code,
                           input logic [11:0] fg, input bit box, input bit von);
        bus.x_pos = 10'd100; bus.y_pos = 10'd50; bus.h_val = h; bus.v_val = 10'd53;
        bus.char_code = code; bus.fg_color = fg;
        bus.box_time = box; bus.video_on_in = von;
        bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
    endtask

    initial begin
        logic [9:0] rx, ry, rh, rv, ddx, ddy;
        for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
        rom[11'h413] = 16'h8000;
        rom[{7'h42, 4'd3}] = 16'h0001;

        // Reset
        set_idle();
        reset_n = 1'b0;
        cycle(); cycle();
        chk("reset_rgb",      16'(bus.rgb),          16'h0000);
        chk("reset_hsync",    16'(bus.hsync_out),    16'h0001);
        chk("reset_vsync",    16'(bus.vsync_out),    16'h0001);
        chk("reset_video_on", 16'(bus.video_on_out), 16'h0000);
        chk("reset_rom_addr", 16'(bus.rom_addr),     16'h0000);

        // Latency and ROM address
        reset_n = 1'b1;
        set_pix(10'd100, 7'h41, 12'hF00, 1'b1, 1'b1);
        cycle();
        chk("rom_addr_413", 16'(bus.rom_addr), 16'h0413);
        set_idle();
        cycle();
        chk("latency_not_early", 16'(bus.rgb), 16'h0000);
        cycle();
        chk("latency_rgb", 16'(bus.rgb), 16'h0F00);

        // Bit order: column 15 maps to bit 0
        set_pix(10'd115, 7'h42, 12'h0F0, 1'b1, 1'b1); cycle();
        set_pix(10'd114, 7'h42, 12'h0F0, 1'b1, 1'b1); cycle();
        set_idle(); cycle();
        chk("bitorder_col15", 16'(bus.rgb), 16'h00F0);
        cycle();
        chk("bitorder_col14", 16'(bus.rgb), 16'h0000);

        // Outside box, blanking, sync alignment
        set_pix(10'd115, 7'h42, 12'h0F0, 1'b0, 1'b1); cycle();
        set_pix(10'd115, 7'h42, 12'h0F0, 1'b1, 1'b0);
        bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; cycle();
        set_idle(); cycle();
        chk("outside_box_rgb", 16'(bus.rgb),       16'h0000);
        chk("hsync_not_early", 16'(bus.hsync_out), 16'h0001);
        cycle();
        chk("blank_rgb",     16'(bus.rgb),       16'h0000);
        chk("hsync_aligned", 16'(bus.hsync_out), 16'h0000);
        chk("vsync_aligned", 16'(bus.vsync_out), 16'h0000);

        // Default foreground colour
        set_pix(10'd115, 7'h42, 12'h000, 1'b1, 1'b1); cycle();
        set_idle(); cycle(); cycle();
        chk("fg_default", 16'(bus.rgb), 16'h0FFF);

        // Randomized traffic, including screen-edge wrap and mid-frame resets
        for (int n = 0; n < 800; n++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            rx = (n % 4 == 0) ? 10'(1023 - $urandom_range(0, 15)) : 10'($urandom);
            ry = 10'($urandom);
            rh = rx + 10'($urandom_range(0, 19));
            rv = ry + 10'($urandom_range(0, 19));
            ddx = rh - rx; ddy = rv - ry;
            bus.x_pos = rx; bus.y_pos = ry; bus.h_val = rh; bus.v_val = rv;
            bus.box_time    = (ddx < 10'd16) && (ddy < 10'd16);
            bus.video_on_in = ($urandom_range(0, 7) != 0);
            bus.hsync_in    = 1'($urandom);
            bus.vsync_in    = 1'($urandom);
            bus.char_code   = 7'($urandom);
            bus.fg_color    = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
            cycle();
        end
        reset_n = 1'b1;

`ifdef CHAR_BLINK_EN
        // Blink phase: 16 frames hidden, 16 frames visible, reset restores visible
        reset_n = 1'b0; set_idle(); cycle();
        reset_n = 1'b1;
        set_pix(10'd100, 7'h41, 12'hF00, 1'b1, 1'b1); cycle();
        for (int k = 0; k < 16; k++) begin
            bus.vsync_in = 1'b0; cycle();
            bus.vsync_in = 1'b1; cycle();
        end
        cycle(); cycle(); cycle();
        chk("blink_hidden", 16'(bus.rgb), 16'h0000);
        for (int k = 0; k < 16; k++) begin
            bus.vsync_in = 1'b0; cycle();
            bus.vsync_in = 1'b1; cycle();
        end
        cycle(); cycle(); cycle();
        chk("blink_visible", 16'(bus.rgb), 16'h0F00);
        for (int k = 0; k < 20; k++) begin
            bus.vsync_in = 1'b0; cycle();
            bus.vsync_in = 1'b1; cycle();
        end
        cycle(); cycle(); cycle();
        chk("blink_hidden_again", 16'(bus.rgb), 16'h0000);
        reset_n = 1'b0; cycle();
        reset_n = 1'b1;
        cycle(); cycle(); cycle();
        chk("blink_after_reset", 16'(bus.rgb), 16'h0F00);
`endif

        set_idle();
        cycle(); cycle(); cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
